// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings: transfer types, burst types, sizes, responses,
// the command-master state encoding and a size-to-increment helper.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b10,
        S_ERR  = 2'b11
    } cmd_state_t;

    // Address increment for one beat of the given HSIZE.
    function automatic logic [31:0] size_bytes(input logic [2:0] size);
        logic [31:0] inc;
        case (size)
            HSIZE_BYTE: inc = 32'd1;
            HSIZE_HALF: inc = 32'd2;
            HSIZE_WORD: inc = 32'd4;
            default:    inc = 32'd1 << size;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single-master initiator: turns a command (addr/size/len/dir)
// into a SINGLE or INCR burst, with one address-phase slot and one
// data-phase slot in flight, wait-state handling and two-cycle ERROR
// handling that cancels the rest of the burst.
module ahb_lite_cmd_master
    import ahb_lite_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic             cmd_write,
    input  logic [2:0]       cmd_size,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      wdata_in,
    output logic             wdata_pop,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    output logic             done,
    output logic             err,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic             HMASTLOCK,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    localparam logic [LEN_W-1:0] ONE_BEAT  = LEN_W'(1);
    localparam logic [LEN_W-1:0] MAX_BEATS = LEN_W'(MAX_LEN);

    cmd_state_t       state_r,     state_s;
    logic [31:0]      haddr_r,     haddr_s;
    htrans_t          htrans_r,    htrans_s;
    logic             hwrite_r,    hwrite_s;
    logic [2:0]       hsize_r,     hsize_s;
    hburst_t          hburst_r,    hburst_s;
    logic [31:0]      hwdata_r,    hwdata_s;
    logic [LEN_W-1:0] beats_r,     beats_s;   // beats not yet in the data phase
    logic             dphase_r,    dphase_s;  // a data phase is on the bus
    logic             dwrite_r,    dwrite_s;  // direction of that data phase
    logic             cmd_ready_r, cmd_ready_s;
    logic             rd_valid_r,  rd_valid_s;
    logic [31:0]      rd_data_r,   rd_data_s;
    logic             done_r,      done_s;
    logic             err_r,       err_s;
    logic             pop_s;
    logic [LEN_W-1:0] len_s;

    // Next-state, next-bus-output and strobe logic for the transfer pipeline.
    always_comb begin
        state_s    = state_r;
        haddr_s    = haddr_r;
        htrans_s   = htrans_r;
        hwrite_s   = hwrite_r;
        hsize_s    = hsize_r;
        hburst_s   = hburst_r;
        hwdata_s   = hwdata_r;
        beats_s    = beats_r;
        dphase_s   = dphase_r;
        dwrite_s   = dwrite_r;
        rd_valid_s = 1'b0;
        rd_data_s  = rd_data_r;
        done_s     = 1'b0;
        err_s      = 1'b0;
        pop_s      = 1'b0;
        len_s      = cmd_len;

        // Out-of-range lengths are clamped so the counter can never wrap.
        if (cmd_len == {LEN_W{1'b0}}) begin
            len_s = ONE_BEAT;
        end else if (cmd_len > MAX_BEATS) begin
            len_s = MAX_BEATS;
        end else begin
            len_s = cmd_len;
        end

        case (state_r)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_s  = S_ADDR;
                    haddr_s  = cmd_addr;
                    htrans_s = HTRANS_NONSEQ;
                    hwrite_s = cmd_write;
                    hsize_s  = cmd_size;
                    hburst_s = (len_s == ONE_BEAT) ? HBURST_SINGLE : HBURST_INCR;
                    beats_s  = len_s;
                    dphase_s = 1'b0;
                end else begin
                    htrans_s = HTRANS_IDLE;
                end
            end

            S_ADDR, S_DATA: begin
                if (HREADY) begin
                    // Completing read data phase: capture the beat.
                    if (dphase_r && !dwrite_r && (HRESP == HRESP_OKAY)) begin
                        rd_valid_s = 1'b1;
                        rd_data_s  = HRDATA;
                    end else begin
                        rd_valid_s = 1'b0;
                    end

                    if (state_r == S_ADDR) begin
                        // Pending address phase moves into the data phase.
                        dphase_s = 1'b1;
                        dwrite_s = hwrite_r;
                        beats_s  = beats_r - ONE_BEAT;
                        if (hwrite_r) begin
                            hwdata_s = wdata_in;
                            pop_s    = 1'b1;
                        end else begin
                            pop_s    = 1'b0;
                        end
                        if (beats_r > ONE_BEAT) begin
                            haddr_s  = haddr_r + size_bytes(hsize_r);
                            htrans_s = HTRANS_SEQ;
                        end else begin
                            htrans_s = HTRANS_IDLE;
                            state_s  = S_DATA;
                        end
                    end else begin
                        // Last data phase done.
                        dphase_s = 1'b0;
                        done_s   = 1'b1;
                        err_s    = (HRESP == HRESP_ERROR);
                        state_s  = S_IDLE;
                    end
                end else if (dphase_r && (HRESP == HRESP_ERROR)) begin
                    // First ERROR cycle: withdraw any pending address phase.
                    htrans_s = HTRANS_IDLE;
                    state_s  = S_ERR;
                end else begin
                    state_s  = state_r;
                end
            end

            S_ERR: begin
                if (HREADY) begin
                    dphase_s = 1'b0;
                    done_s   = 1'b1;
                    err_s    = 1'b1;
                    state_s  = S_IDLE;
                end else begin
                    state_s  = S_ERR;
                end
            end

            default: begin
                state_s  = S_IDLE;
                htrans_s = HTRANS_IDLE;
                dphase_s = 1'b0;
            end
        endcase

        cmd_ready_s = (state_s == S_IDLE);
    end

    // State and registered-output update; async reset returns the bus to IDLE.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= S_IDLE;
            haddr_r     <= 32'd0;
            htrans_r    <= HTRANS_IDLE;
            hwrite_r    <= 1'b0;
            hsize_r     <= HSIZE_BYTE;
            hburst_r    <= HBURST_SINGLE;
            hwdata_r    <= 32'd0;
            beats_r     <= {LEN_W{1'b0}};
            dphase_r    <= 1'b0;
            dwrite_r    <= 1'b0;
            cmd_ready_r <= 1'b1;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= 32'd0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            haddr_r     <= haddr_s;
            htrans_r    <= htrans_s;
            hwrite_r    <= hwrite_s;
            hsize_r     <= hsize_s;
            hburst_r    <= hburst_s;
            hwdata_r    <= hwdata_s;
            beats_r     <= beats_s;
            dphase_r    <= dphase_s;
            dwrite_r    <= dwrite_s;
            cmd_ready_r <= cmd_ready_s;
            rd_valid_r  <= rd_valid_s;
            rd_data_r   <= rd_data_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign wdata_pop = pop_s;
    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_data_r;
    assign done      = done_r;
    assign err       = err_r;
    assign HADDR     = haddr_r;
    assign HTRANS    = htrans_r;
    assign HWRITE    = hwrite_r;
    assign HSIZE     = hsize_r;
    assign HBURST    = hburst_r;
    assign HWDATA    = hwdata_r;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Directed bench for ahb_lite_cmd_master: the bench plays the AHB slave
// cycle by cycle, checks bus outputs directly and checks read data through
// a scoreboard queue filled when each read command is issued.
module tb_ahb_lite_cmd_master;
    import ahb_lite_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [4:0]  cmd_len;
    logic [31:0] wdata_in;
    logic        wdata_pop;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int vectors     = 0;
    int miscompares = 0;
    int pop_cnt     = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int rd_cnt      = 0;
    int base_pop, base_done, base_err, base_rd;
    logic [31:0] rd_q[$];
    logic [31:0] rdat [0:7];
    logic [31:0] wdat [0:3];

    ahb_lite_cmd_master #(.MAX_LEN(16), .LEN_W(5)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_write (cmd_write),
        .cmd_size  (cmd_size),
        .cmd_len   (cmd_len),
        .wdata_in  (wdata_in),
        .wdata_pop (wdata_pop),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_cmd(input logic [31:0] a, input logic w, input logic [2:0] s,
                           input logic [4:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_size  = s;
        cmd_len   = l;
    endtask

    task automatic snap();
        base_pop  = pop_cnt;
        base_done = done_cnt;
        base_err  = err_cnt;
        base_rd   = rd_cnt;
    endtask

    // Monitor: counts strobes and scoreboards read beats mid-cycle.
    initial begin
        forever begin
            @(negedge HCLK);
            if (wdata_pop === 1'b1) pop_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (err === 1'b1) err_cnt++;
            end
            if (rd_valid === 1'b1) begin
                rd_cnt++;
                if (rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL rd_unexpected: observed %h expected no read beat", rd_data);
                end else begin
                    chk("rd_data", rd_data, rd_q.pop_front());
                end
            end
        end
    end

    // Safety net against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rdat[0] = 32'h0BAD_F00D; rdat[1] = 32'h1234_5678;
        rdat[2] = 32'h8765_4321; rdat[3] = 32'hFEED_FACE;
        rdat[4] = 32'hA1A1_0001; rdat[5] = 32'hB2B2_0002;
        rdat[6] = 32'hC3C3_0003; rdat[7] = 32'hD4D4_0004;
        wdat[0] = 32'h1111_AAAA; wdat[1] = 32'h2222_BBBB;
        wdat[2] = 32'h3333_CCCC; wdat[3] = 32'h4444_DDDD;

        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_write = 1'b0;
        cmd_size = 3'd0; cmd_len = 5'd0; wdata_in = 32'd0; HRDATA = 32'd0;
        HREADY = 1'b1; HRESP = 1'b0;
        step(); step();

        // Reset values
        chk("rst_htrans", HTRANS, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwrite", HWRITE, 32'd0);
        chk("rst_hsize", HSIZE, 32'd0);
        chk("rst_hburst", HBURST, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_cmd_ready", cmd_ready, 32'd1);
        chk("rst_done", done, 32'd0);
        chk("rst_err", err, 32'd0);
        chk("rst_rd_valid", rd_valid, 32'd0);
        chk("rst_pop", wdata_pop, 32'd0);
        chk("hprot", HPROT, 32'h3);
        chk("hmastlock", HMASTLOCK, 32'd0);
        HRESETn = 1'b1;
        step();

        // Single write, zero waits
        snap();
        set_cmd(32'h0000_0100, 1'b1, 3'd2, 5'd1);
        wdata_in = 32'hDEAD_BEEF;
        #1 chk("t1_ready", cmd_ready, 32'd1);
        step(); cmd_valid = 1'b0;
        #1;
        chk("t1_c1_htrans", HTRANS, 32'd2);
        chk("t1_c1_haddr", HADDR, 32'h100);
        chk("t1_c1_hburst", HBURST, 32'd0);
        chk("t1_c1_hwrite", HWRITE, 32'd1);
        chk("t1_c1_hsize", HSIZE, 32'd2);
        chk("t1_c1_pop", wdata_pop, 32'd1);
        chk("t1_c1_ready", cmd_ready, 32'd0);
        step(); wdata_in = 32'd0;
        #1;
        chk("t1_c2_htrans", HTRANS, 32'd0);
        chk("t1_c2_hwdata", HWDATA, 32'hDEAD_BEEF);
        chk("t1_c2_done", done, 32'd0);
        step(); #1;
        chk("t1_c3_done", done, 32'd1);
        chk("t1_c3_err", err, 32'd0);
        chk("t1_c3_ready", cmd_ready, 32'd1);
        step(); #1;
        chk("t1_c4_done", done, 32'd0);
        chk("t1_pops", pop_cnt - base_pop, 32'd1);

        // 4-beat read, two wait states on the third beat
        snap();
        for (int i = 0; i < 4; i++) rd_q.push_back(rdat[i]);
        set_cmd(32'h0000_0200, 1'b0, 3'd2, 5'd4);
        step(); cmd_valid = 1'b0;
        #1;
        chk("t2_c1_htrans", HTRANS, 32'd2);
        chk("t2_c1_haddr", HADDR, 32'h200);
        chk("t2_c1_hburst", HBURST, 32'd1);
        chk("t2_c1_hwrite", HWRITE, 32'd0);
        step(); HRDATA = rdat[0];
        #1;
        chk("t2_c2_htrans", HTRANS, 32'd3);
        chk("t2_c2_haddr", HADDR, 32'h204);
        step(); HRDATA = rdat[1];
        #1;
        chk("t2_c3_htrans", HTRANS, 32'd3);
        chk("t2_c3_haddr", HADDR, 32'h208);
        step(); HRDATA = 32'd0; HREADY = 1'b0;
        #1;
        chk("t2_c4_htrans", HTRANS, 32'd3);
        chk("t2_c4_haddr", HADDR, 32'h20C);
        step(); #1;
        chk("t2_c5_htrans", HTRANS, 32'd3);
        chk("t2_c5_haddr", HADDR, 32'h20C);
        chk("t2_c5_rd_valid", rd_valid, 32'd0);
        step(); HREADY = 1'b1; HRDATA = rdat[2];
        #1;
        chk("t2_c6_htrans", HTRANS, 32'd3);
        chk("t2_c6_haddr", HADDR, 32'h20C);
        step(); HRDATA = rdat[3];
        #1;
        chk("t2_c7_htrans", HTRANS, 32'd0);
        chk("t2_c7_done", done, 32'd0);
        step(); HRDATA = 32'd0;
        #1;
        chk("t2_c8_done", done, 32'd1);
        chk("t2_c8_err", err, 32'd0);
        step(); #1;
        chk("t2_rd_count", rd_cnt - base_rd, 32'd4);
        chk("t2_rd_q_empty", rd_q.size(), 32'd0);
        chk("t2_done_count", done_cnt - base_done, 32'd1);

        // Halfword INCR write, three beats
        snap();
        set_cmd(32'h0000_0010, 1'b1, 3'd1, 5'd3);
        wdata_in = wdat[0];
        step(); cmd_valid = 1'b0;
        #1;
        chk("t3_c1_htrans", HTRANS, 32'd2);
        chk("t3_c1_haddr", HADDR, 32'h10);
        chk("t3_c1_hburst", HBURST, 32'd1);
        chk("t3_c1_hsize", HSIZE, 32'd1);
        chk("t3_c1_pop", wdata_pop, 32'd1);
        step(); wdata_in = wdat[1];
        #1;
        chk("t3_c2_htrans", HTRANS, 32'd3);
        chk("t3_c2_haddr", HADDR, 32'h12);
        chk("t3_c2_hwdata", HWDATA, wdat[0]);
        step(); wdata_in = wdat[2];
        #1;
        chk("t3_c3_haddr", HADDR, 32'h14);
        chk("t3_c3_hwdata", HWDATA, wdat[1]);
        step(); wdata_in = 32'd0;
        #1;
        chk("t3_c4_htrans", HTRANS, 32'd0);
        chk("t3_c4_hwdata", HWDATA, wdat[2]);
        chk("t3_c4_pop", wdata_pop, 32'd0);
        step(); #1;
        chk("t3_c5_done", done, 32'd1);
        chk("t3_c5_err", err, 32'd0);
        step(); #1;
        chk("t3_pops", pop_cnt - base_pop, 32'd3);

        // ERROR on the first beat of a 4-beat write
        snap();
        set_cmd(32'h0000_F000, 1'b1, 3'd2, 5'd4);
        wdata_in = wdat[3];
        step(); cmd_valid = 1'b0;
        #1;
        chk("t4_c1_htrans", HTRANS, 32'd2);
        chk("t4_c1_haddr", HADDR, 32'hF000);
        step(); wdata_in = wdat[0]; HREADY = 1'b0; HRESP = 1'b1;
        #1;
        chk("t4_c2_htrans", HTRANS, 32'd3);
        chk("t4_c2_hwdata", HWDATA, wdat[3]);
        chk("t4_c2_pop", wdata_pop, 32'd0);
        step(); HREADY = 1'b1; HRESP = 1'b1;
        #1;
        chk("t4_c3_htrans", HTRANS, 32'd0);
        chk("t4_c3_pop", wdata_pop, 32'd0);
        chk("t4_c3_done", done, 32'd0);
        step(); HRESP = 1'b0;
        #1;
        chk("t4_c4_done", done, 32'd1);
        chk("t4_c4_err", err, 32'd1);
        chk("t4_c4_htrans", HTRANS, 32'd0);
        step(); #1;
        chk("t4_c5_htrans", HTRANS, 32'd0);
        chk("t4_c5_done", done, 32'd0);
        chk("t4_pops", pop_cnt - base_pop, 32'd1);
        chk("t4_err_count", err_cnt - base_err, 32'd1);

        // Reset during beat 2 of a 4-beat write
        snap();
        set_cmd(32'h0000_0500, 1'b1, 3'd2, 5'd4);
        wdata_in = wdat[1];
        step(); cmd_valid = 1'b0;
        #1;
        chk("t5_c1_htrans", HTRANS, 32'd2);
        step(); wdata_in = wdat[2];
        #1;
        chk("t5_c2_haddr", HADDR, 32'h504);
        HRESETn = 1'b0;
        #1;
        chk("t5_rst_htrans", HTRANS, 32'd0);
        chk("t5_rst_ready", cmd_ready, 32'd1);
        chk("t5_rst_haddr", HADDR, 32'd0);
        chk("t5_rst_hwdata", HWDATA, 32'd0);
        chk("t5_rst_pop", wdata_pop, 32'd0);
        step(); step();
        chk("t5_rst_done", done, 32'd0);
        HRESETn = 1'b1;
        wdata_in = 32'd0;
        step(); step();
        chk("t5_done_count", done_cnt - base_done, 32'd0);
        chk("t5_post_htrans", HTRANS, 32'd0);
        chk("t5_post_ready", cmd_ready, 32'd1);

        // Back-to-back len-2 reads with cmd_valid held
        snap();
        for (int i = 4; i < 8; i++) rd_q.push_back(rdat[i]);
        set_cmd(32'h0000_0300, 1'b0, 3'd2, 5'd2);
        step(); cmd_addr = 32'h0000_0400;
        #1;
        chk("t6_c1_htrans", HTRANS, 32'd2);
        chk("t6_c1_haddr", HADDR, 32'h300);
        chk("t6_c1_ready", cmd_ready, 32'd0);
        step(); HRDATA = rdat[4];
        #1;
        chk("t6_c2_htrans", HTRANS, 32'd3);
        chk("t6_c2_haddr", HADDR, 32'h304);
        step(); HRDATA = rdat[5];
        #1;
        chk("t6_c3_htrans", HTRANS, 32'd0);
        step(); HRDATA = 32'd0;
        #1;
        chk("t6_c4_done", done, 32'd1);
        chk("t6_c4_ready", cmd_ready, 32'd1);
        chk("t6_c4_htrans", HTRANS, 32'd0);
        step(); cmd_valid = 1'b0;
        #1;
        chk("t6_c5_htrans", HTRANS, 32'd2);
        chk("t6_c5_haddr", HADDR, 32'h400);
        chk("t6_c5_done", done, 32'd0);
        step(); HRDATA = rdat[6];
        #1;
        chk("t6_c6_haddr", HADDR, 32'h404);
        step(); HRDATA = rdat[7];
        #1;
        chk("t6_c7_htrans", HTRANS, 32'd0);
        step(); HRDATA = 32'd0;
        #1;
        chk("t6_c8_done", done, 32'd1);
        step(); #1;
        chk("t6_rd_count", rd_cnt - base_rd, 32'd4);
        chk("t6_rd_q_empty", rd_q.size(), 32'd0);
        chk("t6_done_count", done_cnt - base_done, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_lite_cmd_master.md
Name: ahb_lite_cmd_master

Overview:
- AHB-Lite initiator (single master) that turns a simple command interface into SINGLE or INCR bursts on the AHB-Lite bus.
- Sits between the test and DMA command logic and the AHB-Lite decoder/mux.
- Drives the bus side that our default slave and peripheral slaves respond to.
- Handles wait states, address/data phase pipelining and the two-cycle ERROR response, including burst cancellation.

Parameters:
- MAX_LEN, 16, maximum beats per command (cmd_len range 1..MAX_LEN)
- LEN_W, 5, width of cmd_len; must satisfy 2^LEN_W > MAX_LEN

Ports:
- HCLK  input  1  bus clock
- HRESETn  input  1  asynchronous reset, active-low
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_addr  input  32  start address, aligned to cmd_size
- cmd_write  input  1  1 = write, 0 = read
- cmd_size  input  3  HSIZE value; only 0..2 (byte/half/word) are legal
- cmd_len  input  LEN_W  beat count; 1 gives SINGLE, >1 gives INCR
- wdata_in  input  32  show-ahead write data; must be valid whenever wdata_pop can assert
- wdata_pop  output  1  consumes one wdata_in word
- rd_valid  output  1  read beat valid
- rd_data  output  32  read beat data
- done  output  1  one-cycle pulse at command completion
- err  output  1  qualifies done: command ended with ERROR
- HADDR  output  32
- HTRANS  output  2
- HWRITE  output  1
- HSIZE  output  3
- HBURST  output  3
- HPROT  output  4  constant 4'b0011
- HMASTLOCK  output  1  constant 0
- HWDATA  output  32
- HRDATA  input  32
- HREADY  input  1
- HRESP  input  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset values (async, HRESETn = 0):
  - HTRANS = IDLE (2'b00), HADDR = 0, HWRITE = 0, HSIZE = 0, HBURST = 0, HWDATA = 0.
  - cmd_ready = 1; rd_valid, rd_data, done, err, wdata_pop = 0; state = S_IDLE.
- All bus outputs are registered.
- State machine S_IDLE, S_ADDR, S_DATA, S_ERR:
  - S_IDLE:
    - cmd_ready = 1.
    - On accept: latch the command, beats_left = cmd_len, go S_ADDR.
    - Next cycle drives HTRANS = NONSEQ, HADDR = cmd_addr, HWRITE/HSIZE from the command, HBURST = 000 (len 1) or 001 (INCR).
  - S_ADDR / S_DATA: a pipeline with one address-phase slot and one data-phase slot.
    - Transfers advance only in cycles with HREADY = 1.
    - HREADY = 1 with an address phase pending:
      - The beat moves to the data phase; beats_left decrements.
      - If beats_left was > 1: HADDR += (1 << HSIZE) and HTRANS = SEQ.
      - Otherwise HTRANS = IDLE.
    - Write beat entering the data phase: HWDATA <= wdata_in and wdata_pop = 1 in that same cycle.
    - HREADY = 1 with a read data phase active: rd_valid = 1 and rd_data = HRDATA, registered (appear one cycle later).
    - HREADY = 0: all bus outputs hold; no pop, no rd_valid.
    - Last data phase completing with OKAY: done = 1, err = 0 the next cycle; return to S_IDLE.
    - cmd_ready = 0 throughout.
  - Error entry:
    - Condition: data phase active, HREADY = 0, HRESP = 1 (first error cycle).
    - Next cycle drives HTRANS = IDLE, cancelling any pending address phase; remaining beats are dropped; go S_ERR.
  - S_ERR:
    - Wait for HREADY = 1 (second error cycle).
    - Then done = 1, err = 1 the next cycle; go S_IDLE.
    - No rd_valid for the errored beat.
- BUSY is never issued.
- Commands must not cross a 1 KB boundary; this is the caller's responsibility and is not checked.
- An illegal cmd_size (> 2) is issued as-is; behaviour is undefined.
- Back-to-back commands:
  - A new command is accepted the cycle done pulses; its NONSEQ follows the next cycle.
  - Minimum one IDLE cycle between commands.
- Zero-wait throughput: one beat per cycle after the first address phase.
- Latency, cmd accept to done (zero waits): len + 2 cycles.
- Reset mid-burst: outputs return to reset values immediately; no done pulse; the partial transfer is abandoned.

Decomposition:
- Shared package ahb_lite_pkg:
  - HTRANS codes IDLE/BUSY/NONSEQ/SEQ.
  - HBURST codes SINGLE/INCR/INCR4…
  - HSIZE codes, HRESP codes.
  - State encodings.
  - Shared with ahb_default_slave and future slaves.
- No sub-module needed; a single module containing the FSM, beat counter and address incrementer.

Test Plan:
- Single write: addr 0x0000_0100, size 2, len 1, wdata 0xDEAD_BEEF, zero waits.
  - Cycle 1: HTRANS = NONSEQ, HBURST = 000.
  - Cycle 2: HWDATA = 0xDEAD_BEEF, HTRANS = IDLE.
  - done = 1, err = 0 at cycle 3.
- 4-beat read: addr 0x200, size 2; slave inserts 2 wait states on beat 3.
  - HADDR = 0x200, 0x204, 0x208, 0x20C, with HTRANS NONSEQ, SEQ, SEQ, SEQ held during waits.
  - 4 rd_valid pulses in order; done after the 4th.
- Halfword INCR write: addr 0x10, size 1, len 3 → HADDR 0x10, 0x12, 0x14; exactly 3 wdata_pop pulses.
- Error mid-burst: len 4 write to the default-slave range; slave returns ERROR on beat 1.
  - HTRANS = IDLE in the 2nd error cycle.
  - No further SEQ; done = 1, err = 1; only 1 pop.
- Reset mid-burst: HRESETn low during beat 2 of 4 → HTRANS = IDLE and cmd_ready = 1 immediately; no done.
- Back-to-back: two len-2 commands with cmd_valid held → second NONSEQ appears exactly 1 IDLE cycle after the first done.
